sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 10: sprite ROM address width (32x32 sprite).
REQ-003 SHALL have parameter DATA_W, default 8: ROM word (palette index) width.
REQ-004 SHALL have parameter MAX_BURST, default 32: maximum consecutive locked grants.
REQ-005 SHALL have port vga_clk  input  1: the single clock; all state on its rising edge.
REQ-006 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  input  N_REQ: per-requester read request.
REQ-008 SHALL have port req_addr  input  N_REQ*ADDR_W: per-requester address, requester i in slice i.
REQ-009 SHALL have port req_lock  input  N_REQ: request to keep the grant for the next read (burst).
REQ-010 SHALL have port req_ready  output  N_REQ: one-hot grant; transfer when req_valid[i] and req_ready[i].
REQ-011 SHALL have port rom_address  output  ADDR_W: address to the synchronous sprite ROM.
REQ-012 SHALL have port rom_q  input  DATA_W: ROM data, valid one clock after the address.
REQ-013 SHALL have port rsp_valid  output  N_REQ: one-hot response strobe.
REQ-014 SHALL have port rsp_data  output  DATA_W: returned palette index.

Function
REQ-015 SHALL grant at most one requester per cycle; req_ready is combinational from req_valid and state.
REQ-016 SHALL drive rom_address with the granted requester's address in the grant cycle; 0 when nothing granted.
REQ-017 SHALL assert rsp_valid[i] with rsp_data = rom_q exactly 2 cycles after a transfer by requester i (T+2), registered.
REQ-018 SHALL sustain one transfer per cycle; responses have no backpressure.
REQ-019 SHALL carry a 2-stage registered requester-tag pipeline so back-to-back responses from different requesters stay ordered.
REQ-020 SHALL use states ARB and LOCKED.
REQ-021 In ARB, SHALL grant the first valid requester searching from rr_ptr upward, wrapping at N_REQ-1 to 0.
REQ-022 After any grant to requester k, rr_ptr SHALL become (k+1) mod N_REQ.
REQ-023 In ARB, grant to k with req_lock[k]=1 SHALL move to LOCKED with owner=k, burst_cnt=1.
REQ-024 In LOCKED, only the owner SHALL be granted; other requesters see req_ready=0.
REQ-025 LOCKED SHALL return to ARB on the cycle owner transfers with req_lock=0, or burst_cnt reaches MAX_BURST, or owner drops req_valid.
REQ-026 If owner drops req_valid in LOCKED, no grant that cycle; ARB resumes next cycle.
REQ-027 burst_cnt SHALL increment per owner transfer; reaching MAX_BURST forces ARB even if req_lock=1.
REQ-028 No valid requests: req_ready=0, rr_ptr and state unchanged.

Reset
REQ-029 reset_n=0 SHALL immediately clear rsp_valid, rsp_data, tag pipeline, rr_ptr=0, burst_cnt=0, state=ARB.
REQ-030 Reads in flight at reset SHALL be discarded; no rsp_valid after reset release for them.
REQ-031 First grant after reset SHALL go to lowest-index valid requester.

Configuration
REQ-032 Macro SPRITE_ARB_LOCK_EN defined: LOCKED state, req_lock and burst_cnt active as above.
REQ-033 Macro undefined: req_lock ignored, state stays ARB, pure round-robin per transfer.

Structure
REQ-034 Shared package sprite_arb_pkg SHALL hold the state enum (ARB, LOCKED) and default parameter constants.
REQ-035 Round-robin selector SHALL be sub-module rr_pick (request vector + pointer -> one-hot grant, index).

Verification
REQ-036 Reset, req_valid=4'b1111, lock=0 -> grants 0,1,2,3,0 on consecutive cycles; rsp_valid follows at T+2.
REQ-037 Requester 2 alone, addr=10'd37, ROM model word 37=8'hA5 -> rsp_valid=4'b0100, rsp_data=8'hA5 two cycles after transfer.
REQ-038 LOCK_EN, req 1 lock=1 for 40 cycles, req 0 valid -> 32 grants to 1, then grant to 0 (MAX_BURST=32).
REQ-039 LOCK_EN, req 3 lock, drops req_valid mid-burst -> one idle cycle, then rr from pointer 0.
REQ-040 reset_n pulsed low with two reads in flight -> rsp_valid=0 immediately and stays 0 until new transfer +2.
REQ-041 Macro undefined, req 1 lock=1 with req 2 valid -> alternating grants 1,2,1,2.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// -----------------------------------------------------------------------------
// sprite_arb_pkg
// Shared definitions for the sprite ROM arbiter:
//   - arb_state_e : arbiter FSM states (ARB, LOCKED)
//   - DEF_*       : default parameter values for the arbiter
//   - idx_width() : index width for an N-entry vector (never below 1 bit)
// -----------------------------------------------------------------------------
package sprite_arb_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 32;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Round-robin selector: finds the first set bit of req starting at ptr and
// searching upward, wrapping from N-1 back to 0.
// Ports:
//   req   [N-1:0]  : request vector
//   ptr   [IW-1:0] : search start position (must be < N)
//   grant [N-1:0]  : one-hot grant (all zero when req is empty)
//   idx   [IW-1:0] : index of the granted bit (0 when nothing granted)
//   found          : at least one request was present
// -----------------------------------------------------------------------------
module rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int N  = DEF_N_REQ,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  // One extra bit so ptr + offset can be wrapped without overflow.
  logic [IW:0] cand_s;

  // Rotating priority search starting at ptr.
  always_comb begin
    grant  = '0;
    idx    = '0;
    found  = 1'b0;
    cand_s = '0;
    for (int off = 0; off < N; off++) begin
      cand_s = {1'b0, ptr} + (IW+1)'(off);
      if (cand_s >= (IW+1)'(N)) begin
        cand_s = cand_s - (IW+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!found && req[cand_s[IW-1:0]]) begin
        grant[cand_s[IW-1:0]] = 1'b1;
        idx                   = cand_s[IW-1:0];
        found                 = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
// Shares one synchronous sprite ROM among N_REQ requesters. One read per
// cycle; the response returns two cycles after the transfer, tagged one-hot
// with the requester that issued it.
//
// Optional feature macro: SPRITE_ARB_LOCK_EN
//   defined   : req_lock lets the current owner keep the grant (burst), up to
//               MAX_BURST consecutive grants, via the LOCKED state.
//   undefined : req_lock is ignored; plain round-robin on every transfer.
//
// Ports:
//   vga_clk      : clock, all state on the rising edge
//   reset_n      : asynchronous active-low reset
//   req_valid    [N_REQ]        : per-requester read request
//   req_addr     [N_REQ*ADDR_W] : per-requester address, requester i in slice i
//   req_lock     [N_REQ]        : keep the grant for the next read
//   req_ready    [N_REQ]        : one-hot grant (combinational)
//   rom_address  [ADDR_W]       : address to the ROM in the grant cycle, else 0
//   rom_q        [DATA_W]       : ROM data, valid one cycle after the address
//   rsp_valid    [N_REQ]        : one-hot response strobe (registered)
//   rsp_data     [DATA_W]       : returned palette index (registered)
// -----------------------------------------------------------------------------
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ-1:0]        req_lock,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data
);

  localparam int IDX_W = idx_width(N_REQ);

  arb_state_e         state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [N_REQ-1:0]   tag_p1_r;
  logic [N_REQ-1:0]   tag_p2_r;
  logic [DATA_W-1:0]  rsp_data_r;

  logic [N_REQ-1:0]   pick_grant_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_found_s;
  logic [N_REQ-1:0]   grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic [IDX_W-1:0]   next_ptr_s;
  logic [ADDR_W-1:0]  addr_s;

`ifdef SPRITE_ARB_LOCK_EN
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  logic [IDX_W-1:0]   owner_r;
  logic [BURST_W-1:0] burst_cnt_r;
  logic [BURST_W-1:0] burst_inc_s;
  logic               owner_drop_s;

  assign burst_inc_s = burst_cnt_r + BURST_W'(1);
`else
  // Lock requests have no effect in this build.
  logic unused_lock_s;
  assign unused_lock_s = &{1'b0, req_lock};
`endif

  rr_pick #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Grant selection: round-robin in ARB, owner only while LOCKED.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = pick_idx_s;
`ifdef SPRITE_ARB_LOCK_EN
    owner_drop_s = 1'b0;
    if (state_r == LOCKED) begin
      grant_idx_s = owner_r;
      if (req_valid[owner_r]) begin
        grant_s[owner_r] = 1'b1;
      end else begin
        // Owner gave up mid-burst: this cycle is idle, ARB resumes next cycle.
        owner_drop_s = 1'b1;
      end
    end else begin
      grant_s = pick_grant_s;
    end
`else
    grant_s = pick_grant_s;
`endif
  end

  // Pointer advances to the slot after whoever was granted.
  always_comb begin
    next_ptr_s = '0;
    if (grant_idx_s == IDX_W'(N_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_idx_s + IDX_W'(1);
    end
  end

  // ROM address mux: granted requester's slice, zero when idle.
  always_comb begin
    addr_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s[i]) begin
        addr_s = req_addr[i*ADDR_W +: ADDR_W];
      end else begin
        addr_s = addr_s;
      end
    end
  end

  assign req_ready   = grant_s;
  assign rom_address = addr_s;

  // Arbiter FSM: state, round-robin pointer, burst owner and length.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ARB;
      rr_ptr_r    <= '0;
`ifdef SPRITE_ARB_LOCK_EN
      owner_r     <= '0;
      burst_cnt_r <= '0;
`endif
    end else begin
      case (state_r)
        ARB: begin
          if (pick_found_s) begin
            rr_ptr_r <= next_ptr_s;
`ifdef SPRITE_ARB_LOCK_EN
            // A single-grant burst limit never needs the LOCKED state.
            if (req_lock[pick_idx_s] && (MAX_BURST > 1)) begin
              state_r     <= LOCKED;
              owner_r     <= pick_idx_s;
              burst_cnt_r <= BURST_W'(1);
            end else begin
              state_r     <= ARB;
              burst_cnt_r <= '0;
            end
`else
            state_r <= ARB;
`endif
          end else begin
            state_r <= ARB;
          end
        end
        LOCKED: begin
`ifdef SPRITE_ARB_LOCK_EN
          if (owner_drop_s) begin
            state_r     <= ARB;
            burst_cnt_r <= '0;
          end else begin
            rr_ptr_r <= next_ptr_s;
            if (!req_lock[owner_r] || (burst_inc_s == BURST_W'(MAX_BURST))) begin
              state_r     <= ARB;
              burst_cnt_r <= '0;
            end else begin
              state_r     <= LOCKED;
              burst_cnt_r <= burst_inc_s;
            end
          end
`else
          state_r <= ARB;
`endif
        end
        default: begin
          state_r <= ARB;
        end
      endcase
    end
  end

  // Response pipeline: tag follows the ROM's one-cycle latency, then the
  // data and tag are registered together so responses leave at T+2.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_p1_r   <= '0;
      tag_p2_r   <= '0;
      rsp_data_r <= '0;
    end else begin
      tag_p1_r <= grant_s;
      tag_p2_r <= tag_p1_r;
      if (|tag_p1_r) begin
        rsp_data_r <= rom_q;
      end else begin
        rsp_data_r <= rsp_data_r;
      end
    end
  end

  assign rsp_valid = tag_p2_r;
  assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic                    vga_clk;
  logic                    reset_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]       rom_address;
  logic [DATA_W-1:0]       rom_q;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;

  int pass_cnt;
  int total_cnt;

  sprite_rom_arbiter #(
    .N_REQ     (N_REQ),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (32)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_lock    (req_lock),
    .req_ready   (req_ready),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  // ROM contents: word a holds a[7:0] ^ 8'h80 (so word 37 = 8'hA5).
  function automatic logic [7:0] rom_word(input logic [9:0] a);
    return a[7:0] ^ 8'h80;
  endfunction

  always @(posedge vga_clk) rom_q <= rom_word(rom_address);

  task automatic set_addr(input int i, input logic [9:0] a);
    req_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic do_reset();
    @(negedge vga_clk);
    reset_n   = 1'b0;
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
    req_addr  = '0;
    @(negedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge vga_clk);
    reset_n   = 1'b0;
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
    req_addr  = '0;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (rsp_data !== 8'h00) $display("FAIL reset_rsp_data got %h want 00", rsp_data);
    else pass_cnt++;
    total_cnt++;
    if (rom_address !== 10'd0) $display("FAIL reset_rom_address got %0d want 0", rom_address);
    else pass_cnt++;
    @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  // All four requesting: grants 0,1,2,3,0, responses two cycles later.
  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    int         exp_i [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_i = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_addr(i, 10'(100 + i));
    for (int c = 0; c < 7; c++) begin
      @(negedge vga_clk);
      req_valid = (c < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 5) begin
        total_cnt++;
        if (req_ready !== exp_g[c]) $display("FAIL rr_grant c%0d got %b want %b", c, req_ready, exp_g[c]);
        else pass_cnt++;
        total_cnt++;
        if (rom_address !== 10'(100 + exp_i[c])) $display("FAIL rr_addr c%0d got %0d want %0d", c, rom_address, 100 + exp_i[c]);
        else pass_cnt++;
      end
      if (c >= 2) begin
        total_cnt++;
        if (rsp_valid !== exp_g[c-2]) $display("FAIL rr_rsp_valid c%0d got %b want %b", c, rsp_valid, exp_g[c-2]);
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== rom_word(10'(100 + exp_i[c-2]))) $display("FAIL rr_rsp_data c%0d got %h want %h", c, rsp_data, rom_word(10'(100 + exp_i[c-2])));
        else pass_cnt++;
      end
    end
  endtask

  // Requester 2 alone reading word 37.
  task automatic test_single_read();
    logic [3:0] exp_v [4];
    exp_v = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    do_reset();
    set_addr(2, 10'd37);
    for (int c = 0; c < 4; c++) begin
      @(negedge vga_clk);
      req_valid = (c == 0) ? 4'b0100 : 4'b0000;
      #1;
      if (c == 0) begin
        total_cnt++;
        if (req_ready !== 4'b0100) $display("FAIL single_grant got %b want 0100", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (rom_address !== 10'd37) $display("FAIL single_addr got %0d want 37", rom_address);
        else pass_cnt++;
      end
      if (c == 1) begin
        total_cnt++;
        if (rom_address !== 10'd0) $display("FAIL idle_addr got %0d want 0", rom_address);
        else pass_cnt++;
      end
      total_cnt++;
      if (rsp_valid !== exp_v[c]) $display("FAIL single_rsp_valid c%0d got %b want %b", c, rsp_valid, exp_v[c]);
      else pass_cnt++;
      if (c == 2) begin
        total_cnt++;
        if (rsp_data !== 8'hA5) $display("FAIL single_rsp_data got %h want a5", rsp_data);
        else pass_cnt++;
      end
    end
  endtask

  // Idle cycles keep the pointer: after a grant to 0, next grant goes to 1.
  task automatic test_idle();
    do_reset();
    @(negedge vga_clk);
    req_valid = 4'b0001;
    @(negedge vga_clk);
    req_valid = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      #1;
      total_cnt++;
      if (req_ready !== 4'b0000) $display("FAIL idle_ready c%0d got %b want 0000", c, req_ready);
      else pass_cnt++;
      @(negedge vga_clk);
    end
    req_valid = 4'b1111;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL idle_resume got %b want 0010", req_ready);
    else pass_cnt++;
    @(negedge vga_clk);
    req_valid = 4'b0000;
  endtask

  // Reset with two reads in flight: responses are dropped.
  task automatic test_reset_inflight();
    do_reset();
    set_addr(0, 10'd11);
    set_addr(1, 10'd22);
    @(negedge vga_clk);
    req_valid = 4'b1111;
    @(negedge vga_clk);
    req_valid = 4'b1111;
    @(negedge vga_clk);
    req_valid = 4'b0000;
    reset_n   = 1'b0;
    #1;
    total_cnt++;
    if (rsp_valid !== 4'b0000) $display("FAIL inflight_rsp_now got %b want 0000", rsp_valid);
    else pass_cnt++;
    @(negedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++;
      if (rsp_valid !== 4'b0000) $display("FAIL inflight_rsp_after c%0d got %b want 0000", c, rsp_valid);
      else pass_cnt++;
      @(negedge vga_clk);
    end
    // First grant after reset goes to the lowest-index valid requester.
    req_valid = 4'b1010;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL post_reset_grant got %b want 0010", req_ready);
    else pass_cnt++;
    @(negedge vga_clk);
    req_valid = 4'b0000;
    @(negedge vga_clk);
    #1;
    total_cnt++;
    if (rsp_valid !== 4'b0010) $display("FAIL post_reset_rsp got %b want 0010", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (rsp_data !== rom_word(10'd22)) $display("FAIL post_reset_data got %h want %h", rsp_data, rom_word(10'd22));
    else pass_cnt++;
  endtask

`ifdef SPRITE_ARB_LOCK_EN
  // Requester 1 bursts: 32 locked grants, then requester 0, then 1 again.
  task automatic test_burst_limit();
    logic [3:0] exp_g;
    do_reset();
    set_addr(0, 10'd300);
    set_addr(1, 10'd200);
    req_lock = 4'b0010;
    for (int c = 0; c < 35; c++) begin
      @(negedge vga_clk);
      if (c == 0) req_valid = 4'b0010;
      else if (c < 34) req_valid = 4'b0011;
      else req_valid = 4'b0000;
      #1;
      if (c < 34) begin
        exp_g = (c == 32) ? 4'b0001 : 4'b0010;
        total_cnt++;
        if (req_ready !== exp_g) $display("FAIL burst_grant c%0d got %b want %b", c, req_ready, exp_g);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (rsp_valid !== 4'b0001) $display("FAIL burst_rsp got %b want 0001", rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== rom_word(10'd300)) $display("FAIL burst_data got %h want %h", rsp_data, rom_word(10'd300));
        else pass_cnt++;
      end
    end
    req_lock = 4'b0000;
  endtask

  // Owner 3 drops valid mid-burst: one idle cycle, then round-robin from 0.
  task automatic test_owner_drop();
    logic [3:0] vals [5];
    logic [3:0] exp_g [5];
    vals  = '{4'b1000, 4'b1000, 4'b0011, 4'b0011, 4'b0011};
    exp_g = '{4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0010};
    do_reset();
    req_lock = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      @(negedge vga_clk);
      req_valid = vals[c];
      #1;
      total_cnt++;
      if (req_ready !== exp_g[c]) $display("FAIL drop_grant c%0d got %b want %b", c, req_ready, exp_g[c]);
      else pass_cnt++;
    end
    @(negedge vga_clk);
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
  endtask
`else
  // Lock ignored: requesters 1 and 2 alternate.
  task automatic test_no_lock();
    logic [3:0] exp_g [4];
    exp_g = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    do_reset();
    req_lock = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      @(negedge vga_clk);
      req_valid = 4'b0110;
      #1;
      total_cnt++;
      if (req_ready !== exp_g[c]) $display("FAIL nolock_grant c%0d got %b want %b", c, req_ready, exp_g[c]);
      else pass_cnt++;
    end
    @(negedge vga_clk);
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b0;
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
    req_addr  = '0;
    test_reset();
    test_round_robin();
    test_single_read();
    test_idle();
    test_reset_inflight();
`ifdef SPRITE_ARB_LOCK_EN
    test_burst_limit();
    test_owner_drop();
`else
    test_no_lock();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
